// File: rtl/seq_div_from_accum.sv
// Sequential signed divider: MAC accumulator P divided by operand-width B.
// Unsigned restoring division on magnitudes, one quotient bit per cycle, saturating quotient.
module seq_div_from_accum #(
    parameter int unsigned Q_W = 20,
    parameter int unsigned D_W = 18,
    parameter int unsigned P_W = 38
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic signed [P_W-1:0] P,
    input  logic signed [D_W-1:0] B,
    output logic signed [Q_W-1:0] Q,
    output logic signed [D_W-1:0] R,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o,
    output logic                  dbz_o
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SH_W  = D_W + 2;
    localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(P_W - 1);
    localparam logic [P_W-1:0]        NEG_LIM   = P_W'(1) << (Q_W - 1);
    localparam logic [P_W-1:0]        POS_LIM   = NEG_LIM - P_W'(1);
    localparam logic signed [Q_W-1:0] Q_MAX     = {1'b0, {(Q_W-1){1'b1}}};
    localparam logic signed [Q_W-1:0] Q_MIN     = {1'b1, {(Q_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Datapath registers
    logic [P_W-1:0]        r_quo;
    logic [D_W:0]          r_rem;
    logic [D_W-1:0]        r_divs;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_zero;
    logic signed [Q_W-1:0] r_q;
    logic signed [D_W-1:0] r_r;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;
    logic                  r_dbz;

    // Next-state values
    logic [P_W-1:0]        w_quo;
    logic [D_W:0]          w_rem;
    logic [D_W-1:0]        w_divs;
    logic [CNT_W-1:0]      w_cnt;
    logic                  w_neg_q;
    logic                  w_neg_r;
    logic                  w_zero;
    logic signed [Q_W-1:0] w_q;
    logic signed [D_W-1:0] w_r;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_ovf;
    logic                  w_dbz;

    // Operand magnitudes and one restoring step
    logic [P_W-1:0]  w_pmag;
    logic [D_W-1:0]  w_bmag;
    logic [SH_W-1:0] w_sh;
    logic [D_W:0]    w_diff;
    logic            w_ge;
    logic            w_b_zero;

    // Magnitudes are unsigned, so -2^(W-1) maps to 2^(W-1) without overflow
    assign w_pmag   = P[P_W-1] ? P_W'(-P) : P_W'(P);
    assign w_bmag   = B[D_W-1] ? D_W'(-B) : D_W'(B);
    assign w_b_zero = (B == '0);

    assign w_sh   = {r_rem, r_quo[P_W-1]};
    assign w_ge   = (w_sh >= {2'b00, r_divs});
    assign w_diff = w_sh[D_W:0] - {1'b0, r_divs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = w_b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_quo   = r_quo;
        w_rem   = r_rem;
        w_divs  = r_divs;
        w_cnt   = r_cnt;
        w_neg_q = r_neg_q;
        w_neg_r = r_neg_r;
        w_zero  = r_zero;
        w_q     = r_q;
        w_r     = r_r;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_ovf   = r_ovf;
        w_dbz   = r_dbz;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_quo   = w_pmag;
                    w_rem   = '0;
                    w_divs  = w_bmag;
                    w_cnt   = '0;
                    w_neg_r = P[P_W-1];
                    w_neg_q = P[P_W-1] ^ B[D_W-1];
                    w_zero  = w_b_zero;
                    w_busy  = 1'b1;
                end
            end
            S_CALC: begin
                w_quo = {r_quo[P_W-2:0], w_ge};
                w_rem = w_ge ? w_diff : w_sh[D_W:0];
                w_cnt = r_cnt + CNT_W'(1);
            end
            S_DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
                if (r_zero) begin
                    w_q   = '0;
                    w_r   = '0;
                    w_ovf = 1'b0;
                    w_dbz = 1'b1;
                end else begin
                    w_dbz = 1'b0;
                    w_ovf = 1'b0;
                    w_r   = r_neg_r ? D_W'(~r_rem + (D_W+1)'(1)) : D_W'(r_rem);
                    // Negative side allows one more magnitude than the positive side
                    if (r_neg_q) begin
                        if (r_quo > NEG_LIM) begin
                            w_q   = Q_MIN;
                            w_ovf = 1'b1;
                        end else begin
                            w_q = Q_W'(~r_quo + P_W'(1));
                        end
                    end else begin
                        if (r_quo > POS_LIM) begin
                            w_q   = Q_MAX;
                            w_ovf = 1'b1;
                        end else begin
                            w_q = Q_W'(r_quo);
                        end
                    end
                end
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_divs  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_quo   <= w_quo;
            r_rem   <= w_rem;
            r_divs  <= w_divs;
            r_cnt   <= w_cnt;
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
            r_zero  <= w_zero;
            r_q     <= w_q;
            r_r     <= w_r;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ovf   <= w_ovf;
            r_dbz   <= w_dbz;
        end
    end

    assign Q      = r_q;
    assign R      = r_r;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign ovf_o  = r_ovf;
    assign dbz_o  = r_dbz;

endmodule

// File: tb/tb_seq_div_from_accum.sv
// Scoreboard bench for seq_div_from_accum: expectations queued at start, checked on done_o.
module tb_seq_div_from_accum;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start_i = 1'b0;
    logic signed [37:0] P = '0;
    logic signed [17:0] B = '0;
    logic signed [19:0] Q;
    logic signed [17:0] R;
    logic               busy_o;
    logic               done_o;
    logic               ovf_o;
    logic               dbz_o;

    typedef struct {
        logic signed [19:0] q;
        logic signed [17:0] r;
        logic               ovf;
        logic               dbz;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   cyc     = 0;

    seq_div_from_accum #(.Q_W(20), .D_W(18), .P_W(38)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .P(P), .B(B),
        .Q(Q), .R(R), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .dbz_o(dbz_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done_o pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (done_o === 1'b1) begin
            n_done++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done at cyc %0d", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL latency: done at cyc %0d, expected %0d", cyc, e.cyc);
                end
                n_tests++;
                if (Q !== e.q) begin
                    n_fail++;
                    $display("FAIL quotient: got %0d expected %0d", Q, e.q);
                end
                n_tests++;
                if (R !== e.r) begin
                    n_fail++;
                    $display("FAIL remainder: got %0d expected %0d", R, e.r);
                end
                n_tests++;
                if (ovf_o !== e.ovf) begin
                    n_fail++;
                    $display("FAIL ovf: got %b expected %b", ovf_o, e.ovf);
                end
                n_tests++;
                if (dbz_o !== e.dbz) begin
                    n_fail++;
                    $display("FAIL dbz: got %b expected %b", dbz_o, e.dbz);
                end
                n_tests++;
                if (busy_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_at_done: got %b expected 0", busy_o);
                end
            end
        end
    end

    task automatic issue(input longint p, input longint b, input longint eq,
                         input longint er, input logic eovf, input logic edbz);
        exp_t e;
        @(negedge clk);
        P       = 38'(p);
        B       = 18'(b);
        start_i = 1'b1;
        e.q   = 20'(eq);
        e.r   = 18'(er);
        e.ovf = eovf;
        e.dbz = edbz;
        e.cyc = cyc + 1 + ((b == 0) ? 1 : 39);
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({Q, R, busy_o, done_o, ovf_o, dbz_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: Q=%0d R=%0d busy=%b done=%b ovf=%b dbz=%b expected all 0",
                     Q, R, busy_o, done_o, ovf_o, dbz_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        issue(10, 2, 5, 0, 1'b0, 1'b0);
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b expected 1", busy_o);
        end
        wait_drain(60);
    endtask

    task automatic test_signs();
        issue(-7,  2, -3, -1, 1'b0, 1'b0); wait_drain(60);
        issue( 7, -2, -3,  1, 1'b0, 1'b0); wait_drain(60);
        issue(-7, -2,  3, -1, 1'b0, 1'b0); wait_drain(60);
        issue(-100, 7, -14, -2, 1'b0, 1'b0); wait_drain(60);
    endtask

    task automatic test_dbz();
        issue(123, 0, 0, 0, 1'b0, 1'b1);
        wait_drain(10);
    endtask

    task automatic test_ovf();
        issue( 64'sd1 << 30,  1,  524287, 0, 1'b1, 1'b0); wait_drain(60);
        issue(-(64'sd1 << 30), 1, -524288, 0, 1'b1, 1'b0); wait_drain(60);
        issue(-(64'sd1 << 37), -(64'sd1 << 17), 524287, 0, 1'b1, 1'b0); wait_drain(60);
        issue(-524288, 1, -524288, 0, 1'b0, 1'b0); wait_drain(60);
        issue( 524288, -1, -524288, 0, 1'b0, 1'b0); wait_drain(60);
        issue( 524288, 1, 524287, 0, 1'b1, 1'b0); wait_drain(60);
        issue(1048579, 2, 524287, 1, 1'b1, 1'b0); wait_drain(60);
    endtask

    task automatic test_round_trip();
        for (int i = 0; i < 32; i++) begin
            longint a, b, base, r, bm;
            a  = longint'($urandom_range(0, 1048575)) - 524288;
            b  = longint'($urandom_range(0, 262143)) - 131072;
            if (b == 0) b = 1;
            bm = (b < 0) ? -b : b;
            r  = longint'($urandom_range(0, 32'(bm - 1)));
            base = a * b;
            if (base < 0 || (base == 0 && i[0])) r = -r;
            issue(base + r, b, a, r, 1'b0, 1'b0);
            wait_drain(60);
        end
    endtask

    task automatic test_busy_ignored();
        int d0;
        d0 = n_done;
        issue(1000, -3, -333, 1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_calc: got %b expected 1", busy_o);
        end
        P = 38'sd5;
        B = 18'sd0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_drain(60);
        repeat (45) @(negedge clk);
        n_tests++;
        if (n_done - d0 !== 1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: %0d done pulses, expected 1", n_done - d0);
        end
    endtask

    // start held through the DONE cycle is taken only at the following IDLE edge
    task automatic test_back_to_back();
        exp_t e1, e2;
        int   c;
        @(negedge clk);
        c = cyc;
        P = 38'sd77; B = 18'sd7; start_i = 1'b1;
        e1.q = 20'sd11; e1.r = 18'sd0; e1.ovf = 1'b0; e1.dbz = 1'b0; e1.cyc = c + 40;
        sb.push_back(e1);
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < c + 39) @(negedge clk);
        P = -38'sd100; B = 18'sd7; start_i = 1'b1;
        e2.q = -20'sd14; e2.r = -18'sd2; e2.ovf = 1'b0; e2.dbz = 1'b0; e2.cyc = c + 80;
        sb.push_back(e2);
        repeat (2) @(negedge clk);
        start_i = 1'b0;
        wait_drain(60);
        repeat (10) @(negedge clk);
        n_tests++;
        if (Q !== -20'sd14 || R !== -18'sd2) begin
            n_fail++;
            $display("FAIL hold_outputs: Q=%0d R=%0d expected -14 -2", Q, R);
        end
    endtask

    task automatic test_reset_abort();
        int c, d0;
        @(negedge clk);
        c = cyc;
        P = 38'sd999; B = 18'sd4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < c + 21) @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({Q, R, busy_o, done_o, ovf_o, dbz_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: Q=%0d R=%0d busy=%b done=%b expected all 0",
                     Q, R, busy_o, done_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        d0 = n_done;
        repeat (50) @(negedge clk);
        n_tests++;
        if (n_done !== d0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d done pulses, expected 0", n_done - d0);
        end
        issue(-999, 4, -249, -3, 1'b0, 1'b0);
        wait_drain(60);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_dbz();
        test_ovf();
        test_round_trip();
        test_busy_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
